// File: rtl/dcache_axi_bridge_pkg.sv
// Shared types and AXI constants for the data-cache to AXI4 bridge.
package dcache_axi_bridge_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AR,
    S_R,
    S_AW_W,
    S_B
  } state_e;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  // Byte count (one-hot 1/2/4/8) to AXI AxSIZE encoding.
  function automatic logic [2:0] size_to_axsize(input logic [3:0] onehot);
    logic [2:0] sz;
    sz = 3'd0;
    case (onehot)
      4'b0001: sz = 3'd0;
      4'b0010: sz = 3'd1;
      4'b0100: sz = 3'd2;
      4'b1000: sz = 3'd3;
      default: sz = 3'd0;
    endcase
    return sz;
  endfunction

endpackage

// File: rtl/dcache_axi_align.sv
// Byte-lane shifter between LSB-aligned cache data and the 64-bit AXI lanes.
module dcache_axi_align #(
  parameter int DATA_W = 64
) (
  input  logic [2:0]          woff_i,
  input  logic [DATA_W/8-1:0] wmask_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W/8-1:0] wstrb_o,
  output logic [DATA_W-1:0]   wdata_o,
  input  logic [2:0]          roff_i,
  input  logic                rshift_i,
  input  logic [DATA_W-1:0]   rdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  // Lanes pushed past the top of the word simply fall off.
  assign wstrb_o = wmask_i << woff_i;
  assign wdata_o = wdata_i << {woff_i, 3'b000};
  assign rdata_o = rshift_i ? (rdata_i >> {roff_i, 3'b000}) : rdata_i;

endmodule

// File: rtl/dcache_axi_bridge.sv
// AXI4 master for the data cache: one read (single or INCR8) or one write-through
// single-beat write at a time, with a sticky bus error flag.
module dcache_axi_bridge
  import dcache_axi_bridge_pkg::*;
#(
  parameter int              ADDR_W = 32,
  parameter int              DATA_W = 64,
  parameter int              ID_W   = 4,
  parameter logic [ID_W-1:0] AXI_ID = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   c_raddr,
  input  logic                c_raddr_valid,
  input  logic [DATA_W/8-1:0] c_rmask,
  input  logic [3:0]          c_rsize,
  input  logic [7:0]          c_rlen,
  output logic                c_rdata_ready,
  output logic [DATA_W-1:0]   c_rdata,
  input  logic [ADDR_W-1:0]   c_waddr,
  input  logic                c_waddr_valid,
  input  logic [DATA_W/8-1:0] c_wmask,
  input  logic [3:0]          c_wsize,
  input  logic [DATA_W-1:0]   c_wdata,
  output logic                c_wdata_ready,
  output logic [ADDR_W-1:0]   m_araddr,
  output logic                m_arvalid,
  input  logic                m_arready,
  output logic [7:0]          m_arlen,
  output logic [2:0]          m_arsize,
  output logic [1:0]          m_arburst,
  output logic [ID_W-1:0]     m_arid,
  input  logic [DATA_W-1:0]   m_rdata,
  input  logic [1:0]          m_rresp,
  input  logic                m_rlast,
  input  logic                m_rvalid,
  output logic                m_rready,
  output logic [ADDR_W-1:0]   m_awaddr,
  output logic                m_awvalid,
  input  logic                m_awready,
  output logic [7:0]          m_awlen,
  output logic [2:0]          m_awsize,
  output logic [1:0]          m_awburst,
  output logic [ID_W-1:0]     m_awid,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  output logic                m_wlast,
  output logic                m_wvalid,
  input  logic                m_wready,
  input  logic [1:0]          m_bresp,
  input  logic                m_bvalid,
  output logic                m_bready,
  output logic                bus_err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   raddr_q, raddr_d, waddr_q, waddr_d;
  logic [7:0]          rlen_q, rlen_d, beat_q, beat_d;
  logic [2:0]          rsize_q, rsize_d, wsize_q, wsize_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                err_q, err_d;

  // The read mask carries no information the shifter needs.
  logic unused_ok;
  assign unused_ok = ^c_rmask;

  always_comb begin
    state_d       = state_q;
    raddr_d       = raddr_q;
    rlen_d        = rlen_q;
    rsize_d       = rsize_q;
    beat_d        = beat_q;
    waddr_d       = waddr_q;
    wsize_d       = wsize_q;
    wmask_d       = wmask_q;
    wdata_d       = wdata_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    err_d         = err_q;
    m_arvalid     = 1'b0;
    m_rready      = 1'b0;
    m_awvalid     = 1'b0;
    m_wvalid      = 1'b0;
    m_bready      = 1'b0;
    c_rdata_ready = 1'b0;
    c_wdata_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (c_waddr_valid) begin
          state_d   = S_AW_W;
          waddr_d   = c_waddr;
          wsize_d   = size_to_axsize(c_wsize);
          wmask_d   = c_wmask;
          wdata_d   = c_wdata;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end else if (c_raddr_valid) begin
          state_d = S_AR;
          raddr_d = c_raddr;
          rlen_d  = c_rlen;
          rsize_d = size_to_axsize(c_rsize);
        end
      end
      S_AR: begin
        m_arvalid = 1'b1;
        if (m_arready) begin
          state_d = S_R;
          beat_d  = '0;
        end
      end
      S_R: begin
        m_rready = 1'b1;
        if (m_rvalid) begin
          c_rdata_ready = 1'b1;
          beat_d        = beat_q + 8'd1;
          // rlast must coincide exactly with the final counted beat.
          if (m_rresp != AXI_RESP_OKAY || (m_rlast != (beat_q == rlen_q))) err_d = 1'b1;
          if (m_rlast) state_d = S_IDLE;
        end
      end
      S_AW_W: begin
        m_awvalid = !aw_done_q;
        m_wvalid  = !w_done_q;
        if (!aw_done_q && m_awready) aw_done_d = 1'b1;
        if (!w_done_q && m_wready) w_done_d = 1'b1;
        if (aw_done_d && w_done_d) state_d = S_B;
      end
      S_B: begin
        m_bready = 1'b1;
        if (m_bvalid) begin
          c_wdata_ready = 1'b1;
          if (m_bresp != AXI_RESP_OKAY) err_d = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rsize_q   <= '0;
      beat_q    <= '0;
      waddr_q   <= '0;
      wsize_q   <= '0;
      wmask_q   <= '0;
      wdata_q   <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      raddr_q   <= raddr_d;
      rlen_q    <= rlen_d;
      rsize_q   <= rsize_d;
      beat_q    <= beat_d;
      waddr_q   <= waddr_d;
      wsize_q   <= wsize_d;
      wmask_q   <= wmask_d;
      wdata_q   <= wdata_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      err_q     <= err_d;
    end
  end

  dcache_axi_align #(.DATA_W(DATA_W)) u_align (
    .woff_i   (waddr_q[2:0]),
    .wmask_i  (wmask_q),
    .wdata_i  (wdata_q),
    .wstrb_o  (m_wstrb),
    .wdata_o  (m_wdata),
    .roff_i   (raddr_q[2:0]),
    .rshift_i (rlen_q == 8'd0),
    .rdata_i  (m_rdata),
    .rdata_o  (c_rdata)
  );

  assign m_araddr  = raddr_q;
  assign m_arlen   = rlen_q;
  assign m_arsize  = rsize_q;
  assign m_arburst = AXI_BURST_INCR;
  assign m_arid    = AXI_ID;
  assign m_awaddr  = waddr_q;
  assign m_awlen   = 8'd0;
  assign m_awsize  = wsize_q;
  assign m_awburst = AXI_BURST_INCR;
  assign m_awid    = AXI_ID;
  assign m_wlast   = 1'b1;
  assign bus_err   = err_q;

endmodule

// File: tb/tb_dcache_axi_bridge.sv
// Randomized scoreboard bench for dcache_axi_bridge with an AXI slave model.
module tb_dcache_axi_bridge;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] c_raddr, c_waddr, m_araddr, m_awaddr;
  logic [7:0]  c_rmask, c_rlen, c_wmask, m_arlen, m_awlen, m_wstrb;
  logic [3:0]  c_rsize, c_wsize, m_arid, m_awid;
  logic [63:0] c_rdata, c_wdata, m_rdata, m_wdata;
  logic [2:0]  m_arsize, m_awsize;
  logic [1:0]  m_arburst, m_awburst, m_rresp, m_bresp;
  logic c_raddr_valid, c_rdata_ready, c_waddr_valid, c_wdata_ready;
  logic m_arvalid, m_arready, m_rlast, m_rvalid, m_rready;
  logic m_awvalid, m_awready, m_wlast, m_wvalid, m_wready, m_bvalid, m_bready, bus_err;

  dcache_axi_bridge dut (
    .clk(clk), .rst(rst),
    .c_raddr(c_raddr), .c_raddr_valid(c_raddr_valid), .c_rmask(c_rmask), .c_rsize(c_rsize),
    .c_rlen(c_rlen), .c_rdata_ready(c_rdata_ready), .c_rdata(c_rdata),
    .c_waddr(c_waddr), .c_waddr_valid(c_waddr_valid), .c_wmask(c_wmask), .c_wsize(c_wsize),
    .c_wdata(c_wdata), .c_wdata_ready(c_wdata_ready),
    .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arlen(m_arlen),
    .m_arsize(m_arsize), .m_arburst(m_arburst), .m_arid(m_arid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rvalid(m_rvalid), .m_rready(m_rready),
    .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awlen(m_awlen),
    .m_awsize(m_awsize), .m_awburst(m_awburst), .m_awid(m_awid),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
    .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready), .bus_err(bus_err)
  );

  typedef struct { logic [31:0] addr; logic [7:0] len; logic [2:0] size; } ax_t;
  typedef struct { logic [63:0] data; logic [7:0] strb; } w_t;

  int n_vec = 0, n_err = 0;
  longint cyc = 0, ar_cyc = 0, b_cyc = 0;
  logic [63:0] mem [256];
  logic [63:0] exp_rd_q [$];
  ax_t exp_ar_q [$], exp_aw_q [$];
  w_t  exp_w_q [$];
  int  ord_q [$];
  // Slave knobs: negative delay means random; injections apply to the next transaction.
  int aw_dly = -1, w_dly = -1, early_last = -1;
  logic [1:0] bresp_inj = 2'b00, rresp_inj = 2'b00;
  logic exp_err = 1'b0;

  initial forever begin @(posedge clk); cyc++; end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    n_vec++; n_err++;
    $display("FAIL %s: got event/timeout expected none", name);
  endtask

  function automatic logic [7:0] size_mask(input int sz);
    return 8'((1 << sz) - 1);
  endfunction

  task automatic do_read(input logic [31:0] addr, input int sz, input int len, input int nbeats);
    ax_t a;
    int got, t, idx;
    a.addr = addr; a.len = 8'(len); a.size = 3'($clog2(sz));
    exp_ar_q.push_back(a);
    for (int b = 0; b < nbeats; b++) begin
      idx = (int'(addr[10:3]) + b) & 255;
      exp_rd_q.push_back(len == 0 ? (mem[idx] >> (8 * int'(addr[2:0]))) : mem[idx]);
    end
    c_raddr = addr; c_rsize = 4'(sz); c_rlen = 8'(len);
    c_rmask = (len == 0) ? size_mask(sz) : 8'hFF;
    c_raddr_valid = 1'b1;
    got = 0; t = 0;
    while (got < nbeats && t < 400) begin
      @(negedge clk);
      if (c_rdata_ready) got++;
      t++;
    end
    if (got < nbeats) fail("read_timeout");
    tick();
    c_raddr_valid = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] addr, input int sz, input logic [63:0] data);
    ax_t a;
    w_t  w;
    logic [63:0] d;
    logic [7:0]  m;
    int t;
    logic got;
    m = size_mask(sz);
    d = (sz == 8) ? data : (data & ((64'd1 << (8 * sz)) - 64'd1));
    a.addr = addr; a.len = 8'd0; a.size = 3'($clog2(sz));
    w.data = d << (8 * int'(addr[2:0]));
    w.strb = 8'(m << addr[2:0]);
    exp_aw_q.push_back(a);
    exp_w_q.push_back(w);
    c_waddr = addr; c_wsize = 4'(sz); c_wmask = m; c_wdata = d;
    c_waddr_valid = 1'b1;
    got = 1'b0; t = 0;
    while (!got && t < 400) begin
      @(negedge clk);
      got = c_wdata_ready;
      t++;
    end
    if (!got) fail("write_timeout");
    tick();
    c_waddr_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_awvalid", m_awvalid, 0);
    chk("rst_wvalid", m_wvalid, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_bready", m_bready, 0);
    chk("rst_c_rdata_ready", c_rdata_ready, 0);
    chk("rst_c_wdata_ready", c_wdata_ready, 0);
    chk("rst_bus_err", bus_err, 0);
    exp_err = 1'b0;
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Monitor: every handshake pops and compares the oldest expectation.
  initial begin : monitor
    ax_t e;
    w_t  w;
    forever begin
      @(negedge clk);
      if (m_arvalid && m_arready) begin
        if (exp_ar_q.size() == 0) fail("ar_unexpected");
        else begin
          e = exp_ar_q.pop_front();
          chk("ar_addr", m_araddr, e.addr);
          chk("ar_len", m_arlen, e.len);
          chk("ar_size", m_arsize, e.size);
          chk("ar_burst_id", {m_arburst, m_arid}, {2'b01, 4'h0});
        end
        ord_q.push_back(0);
        ar_cyc = cyc;
      end
      if (c_rdata_ready) begin
        if (exp_rd_q.size() == 0) fail("rdata_unexpected");
        else chk("rdata", c_rdata, exp_rd_q.pop_front());
      end
      if (m_awvalid && m_awready) begin
        if (exp_aw_q.size() == 0) fail("aw_unexpected");
        else begin
          e = exp_aw_q.pop_front();
          chk("aw_addr", m_awaddr, e.addr);
          chk("aw_len", m_awlen, e.len);
          chk("aw_size", m_awsize, e.size);
          chk("aw_burst_id", {m_awburst, m_awid}, {2'b01, 4'h0});
        end
        ord_q.push_back(1);
      end
      if (m_wvalid && m_wready) begin
        if (exp_w_q.size() == 0) fail("w_unexpected");
        else begin
          w = exp_w_q.pop_front();
          chk("wdata", m_wdata, w.data);
          chk("wstrb", m_wstrb, w.strb);
          chk("wlast", m_wlast, 1);
        end
      end
      if (m_bvalid && m_bready) begin
        chk("b_c_wdata_ready", c_wdata_ready, 1);
        chk("b_after_aw_and_w", 64'(exp_aw_q.size() + exp_w_q.size()), 0);
        b_cyc = cyc;
      end else if (c_wdata_ready) fail("c_wdata_ready_spurious");
    end
  end

  initial begin : ar_slave
    logic [31:0] sa;
    int nb, idx;
    logic [1:0] rr;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_rdata = '0; m_rresp = 2'b00;
    forever begin
      @(negedge clk);
      if (m_arvalid && !rst) begin
        sa = m_araddr;
        nb = (early_last >= 0) ? early_last + 1 : int'(m_arlen) + 1;
        rr = rresp_inj;
        early_last = -1; rresp_inj = 2'b00;
        tick();
        repeat ($urandom_range(0, 2)) tick();
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        for (int b = 0; b < nb; b++) begin
          repeat ((b == 2 || b == 5) ? 1 : $urandom_range(0, 1)) tick();
          idx = (int'(sa[10:3]) + b) & 255;
          m_rvalid = 1'b1; m_rdata = mem[idx]; m_rlast = (b == nb - 1); m_rresp = rr;
          tick();
          m_rvalid = 1'b0; m_rlast = 1'b0; m_rresp = 2'b00;
        end
      end
    end
  end

  initial begin : aw_slave
    int da, dw, k;
    logic ag, wg;
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = 2'b00;
    forever begin
      @(negedge clk);
      if ((m_awvalid || m_wvalid) && !rst) begin
        da = (aw_dly >= 0) ? aw_dly : $urandom_range(0, 2);
        dw = (w_dly >= 0) ? w_dly : $urandom_range(0, 2);
        aw_dly = -1; w_dly = -1;
        ag = 1'b0; wg = 1'b0; k = 0;
        while (!(ag && wg) && k < 50) begin
          tick();
          m_awready = !ag && k >= da;
          m_wready  = !wg && k >= dw;
          @(negedge clk);
          if (m_awvalid && m_awready) ag = 1'b1;
          if (m_wvalid && m_wready) wg = 1'b1;
          k++;
        end
        tick();
        m_awready = 1'b0; m_wready = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
        m_bvalid = 1'b1; m_bresp = bresp_inj; bresp_inj = 2'b00;
        k = 0;
        do begin @(negedge clk); k++; end while (!m_bready && k < 50);
        tick();
        m_bvalid = 1'b0; m_bresp = 2'b00;
      end
    end
  end

  initial begin : stim
    int kind, sz, len;
    logic [31:0] ra, wa;
    c_raddr = '0; c_raddr_valid = 1'b0; c_rmask = '0; c_rsize = '0; c_rlen = '0;
    c_waddr = '0; c_waddr_valid = 1'b0; c_wmask = '0; c_wsize = '0; c_wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom};
    mem[0] = 64'h1122_3344_5566_7788;
    do_reset();

    do_read(32'h8000_0004, 4, 0, 1);
    do_read(32'h8000_0040, 8, 7, 8);
    do_write(32'h8000_0006, 2, 64'hBEEF);
    w_dly = 0; aw_dly = 3;
    do_write(32'h8000_0010, 8, {$urandom, $urandom});

    ord_q.delete();
    fork
      do_write(32'h8000_0020, 4, {$urandom, $urandom});
      do_read(32'h8000_0100, 8, 7, 8);
    join
    chk("both_order_count", 64'(ord_q.size()), 2);
    if (ord_q.size() == 2) chk("both_aw_first", 64'(ord_q[0]), 1);
    chk("both_read_after_b", ar_cyc > b_cyc, 1);
    chk("no_err_clean", bus_err, 0);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      len  = $urandom_range(0, 1) ? 7 : 0;
      sz   = (len == 7) ? 8 : (1 << $urandom_range(0, 3));
      ra   = 32'h8000_0000 | (32'($urandom_range(0, 2047)) & ~32'(sz - 1));
      sz   = (kind == 0) ? sz : sz;
      if (kind == 0) do_read(ra, sz, len, len + 1);
      else begin
        int wsz;
        wsz = 1 << $urandom_range(0, 3);
        wa  = 32'h8000_0000 | (32'($urandom_range(0, 2047)) & ~32'(wsz - 1));
        if (kind == 1) do_write(wa, wsz, {$urandom, $urandom});
        else fork
          do_write(wa, wsz, {$urandom, $urandom});
          do_read(ra, sz, len, len + 1);
        join
      end
    end
    chk("no_err_random", bus_err, exp_err);

    bresp_inj = 2'b10; exp_err = 1'b1;
    do_write(32'h8000_0008, 8, {$urandom, $urandom});
    chk("err_bresp", bus_err, exp_err);
    do_read(32'h8000_0200, 8, 7, 8);
    chk("err_sticky", bus_err, exp_err);
    do_reset();
    early_last = 3; exp_err = 1'b1;
    do_read(32'h8000_0300, 8, 7, 4);
    chk("err_early_rlast", bus_err, exp_err);
    do_read(32'h8000_0002, 2, 0, 1);
    chk("err_sticky2", bus_err, exp_err);
    do_reset();
    rresp_inj = 2'b11; exp_err = 1'b1;
    do_read(32'h8000_0001, 1, 0, 1);
    chk("err_rresp", bus_err, exp_err);

    repeat (5) tick();
    chk("leftover_expectations",
        64'(exp_rd_q.size() + exp_ar_q.size() + exp_aw_q.size() + exp_w_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
